// File: rtl/ex_muldiv_pkg.sv
// Shared funct codes and bus widths for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned MD_DATA_W = 32;
  localparam int unsigned FUNCT_W   = 6;

  typedef logic [FUNCT_W-1:0] funct_t;

  localparam funct_t FUNCT_MFHI  = 6'h10;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MFLO  = 6'h12;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1A;
  localparam funct_t FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Only built when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module ex_muldiv_div_core
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W     = MD_DATA_W,
  parameter int unsigned DIV_CYCLES = MD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  // quotient doubles as the dividend shift register
  assign shifted = {remainder, quotient[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvs};

  // done marks the final iteration; quotient/remainder are valid the cycle after
  assign done = busy && (cnt == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= '0;
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
      if (trial[DATA_W]) begin
        remainder <= shifted[DATA_W-1:0];
        quotient  <= {quotient[DATA_W-2:0], 1'b0};
      end else begin
        remainder <= trial[DATA_W-1:0];
        quotient  <= {quotient[DATA_W-2:0], 1'b1};
      end
      if (done) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_DIV_EN to include the sequential divider; otherwise DIV/DIVU are NOPs.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W     = MD_DATA_W,
  parameter int unsigned DIV_CYCLES = MD_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  operand_1,
  input  logic [DATA_W-1:0]  operand_2,
  output logic               stall_req,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  if (DIV_CYCLES != DATA_W) begin : g_cfg_check
    $error("ex_muldiv: DIV_CYCLES must equal DATA_W");
  end

  logic              act;
  logic              idle;
  logic [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0] prod_u;
  logic [DATA_W-1:0] hi_nxt;
  logic [DATA_W-1:0] lo_nxt;

  assign act    = en && !flush;
  assign prod_s = PROD_W'($signed(operand_1)) * PROD_W'($signed(operand_2));
  assign prod_u = PROD_W'(operand_1) * PROD_W'(operand_2);

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              start;
  logic              sgn;
  logic              neg_q;
  logic              neg_r;
  logic              core_busy;
  logic              core_done;
  logic [DATA_W-1:0] dvd_abs;
  logic [DATA_W-1:0] dvs_abs;
  logic [DATA_W-1:0] quo_raw;
  logic [DATA_W-1:0] rem_raw;

  assign idle    = (state == S_IDLE);
  assign sgn     = (funct == FUNCT_DIV);
  assign dvd_abs = (sgn && operand_1[DATA_W-1]) ? -operand_1 : operand_1;
  assign dvs_abs = (sgn && operand_2[DATA_W-1]) ? -operand_2 : operand_2;

  ex_muldiv_div_core #(
    .DATA_W     (DATA_W),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .busy      (core_busy),
    .done      (core_done),
    .quotient  (quo_raw),
    .remainder (rem_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        neg_q <= sgn && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
        neg_r <= sgn && operand_1[DATA_W-1];
      end
    end
  end
`else
  assign idle = 1'b1;
`endif

  // HI/LO next value, stall and divider FSM
  always_comb begin
    hi_nxt    = hi;
    lo_nxt    = lo;
    stall_req = 1'b0;
`ifdef MULDIV_DIV_EN
    state_nxt = state;
    start     = 1'b0;
`endif
    if (act && idle) begin
      case (funct)
        FUNCT_MTHI:  hi_nxt = operand_1;
        FUNCT_MTLO:  lo_nxt = operand_1;
        FUNCT_MULT:  {hi_nxt, lo_nxt} = prod_s;
        FUNCT_MULTU: {hi_nxt, lo_nxt} = prod_u;
`ifdef MULDIV_DIV_EN
        FUNCT_DIV, FUNCT_DIVU: begin
          if (operand_2 == '0) begin
            hi_nxt = operand_1;
            lo_nxt = '1;
          end else begin
            stall_req = 1'b1;
            start     = 1'b1;
            state_nxt = S_RUN;
          end
        end
`endif
        default: ;
      endcase
    end
`ifdef MULDIV_DIV_EN
    unique case (state)
      S_IDLE: ;
      S_RUN: begin
        stall_req = 1'b1;
        if (core_busy && core_done) state_nxt = S_DONE;
      end
      S_DONE: begin
        hi_nxt    = neg_r ? -rem_raw : rem_raw;
        lo_nxt    = neg_q ? -quo_raw : quo_raw;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // a squashed instruction never writes HI/LO and abandons any divide
    if (flush) begin
      hi_nxt    = hi;
      lo_nxt    = lo;
      start     = 1'b0;
      state_nxt = S_IDLE;
    end
`endif
  end

  always_comb begin
    result = '0;
    if (act && (funct == FUNCT_MFHI)) result = hi;
    else if (act && (funct == FUNCT_MFLO)) result = lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed, scoreboard-checked bench for ex_muldiv; expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_NOP   = 6'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        stall_req;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .funct     (funct),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .stall_req (stall_req),
    .result    (result),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'h0;
  logic [31:0] m_lo  = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: updates m_hi/m_lo, returns expected stall cycles
  function automatic int model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
`ifdef MULDIV_DIV_EN
    longint q;
    longint r;
`endif
    model = 0;
    case (f)
      F_MTHI:  m_hi = a;
      F_MTLO:  m_lo = a;
      F_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      F_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
`ifdef MULDIV_DIV_EN
      F_DIV: begin
        if (b == 32'h0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0];
          m_hi = r[31:0];
          model = 33;
        end
      end
      F_DIVU: begin
        if (b == 32'h0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
          model = 33;
        end
      end
`endif
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    exp_t e;
    int   stalls;
    e.stalls = model(f, a, b);
    e.hi     = m_hi;
    e.lo     = m_lo;
    sb.push_back(e);
    en = 1'b1; flush = 1'b0; funct = f; operand_1 = a; operand_2 = b;
    #1;
    stalls = 0;
    while (stall_req !== 1'b0 && stalls < 100) begin
      @(posedge clk); #1;
      stalls++;
    end
    @(posedge clk); #1;
    en = 1'b0; funct = F_NOP;
    e = sb.pop_front();
    chk({tag, " stalls"}, 32'(stalls), 32'(e.stalls));
    chk({tag, " hi"}, hi, e.hi);
    chk({tag, " lo"}, lo, e.lo);
  endtask

  task automatic run_mf(input logic [5:0] f, input string tag);
    en = 1'b1; flush = 1'b0; funct = f;
    #1;
    chk({tag, " result"}, result, (f == F_MFHI) ? m_hi : m_lo);
    chk({tag, " stall"}, 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    en = 1'b0; funct = F_NOP;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; funct = F_NOP;
    operand_1 = 32'h0; operand_2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset stall", 32'(stall_req), 32'h0);
    chk("reset result", result, 32'h0);
    @(posedge clk); #1;

    run_op(F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
    run_mf(F_MFLO, "mflo after mult");
    run_mf(F_MFHI, "mfhi after mult");
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");

    // flush beats en: MULT must not write
    en = 1'b1; flush = 1'b1; funct = F_MULT; operand_1 = 32'd5; operand_2 = 32'd6;
    #1;
    chk("flushed mult stall", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b0; funct = F_NOP;
    chk("flushed mult hi", hi, m_hi);
    chk("flushed mult lo", lo, m_lo);

    run_op(F_NOP, 32'h1111_1111, 32'h2222_2222, "nop funct");

    run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div -7/2");
    #1;
    chk("div idle stall a", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    chk("div idle stall b", 32'(stall_req), 32'h0);
    chk("div idle hi", hi, m_hi);

    run_op(F_DIV, 32'h0000_0007, 32'hFFFF_FFFE, "div 7/-2");
    run_op(F_DIVU, 32'd100, 32'h0, "divu by zero");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    run_op(F_DIVU, 32'hFFFF_FFF0, 32'h0000_0003, "divu big");

    run_op(F_MTHI, 32'h1234_5678, 32'h0, "mthi");
    run_op(F_MTLO, 32'h9ABC_DEF0, 32'h0, "mtlo");
    run_mf(F_MFHI, "mfhi");
    run_mf(F_MFLO, "mflo");

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    chk("rst pulse hi", hi, 32'h0);
    chk("rst pulse lo", lo, 32'h0);

    // seed HI/LO so an unwanted write after flush is visible
    run_op(F_MTHI, 32'hCAFE_0001, 32'h0, "seed hi");
    run_op(F_MTLO, 32'hCAFE_0002, 32'h0, "seed lo");

    en = 1'b1; flush = 1'b0; funct = F_DIVU; operand_1 = 32'd50; operand_2 = 32'd7;
    #1;
`ifdef MULDIV_DIV_EN
    chk("flush div issue stall", 32'(stall_req), 32'h1);
`else
    chk("flush div issue stall", 32'(stall_req), 32'h0);
`endif
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b0; funct = F_NOP;
    #1;
    chk("flush div stall drop", 32'(stall_req), 32'h0);
    chk("flush div hi", hi, m_hi);
    chk("flush div lo", lo, m_lo);
    @(posedge clk); #1;
    chk("flush div settled hi", hi, m_hi);

    run_op(F_DIVU, 32'd50, 32'd7, "divu 50/7 after flush");
    run_mf(F_MFLO, "mflo after divu");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
